inv_mixcolumns_seq: RTL



---
 rtl/inv_mixcolumns_seq_if.sv | 31 +++
 rtl/inv_mixcolumns_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/inv_mixcolumns_seq_if.sv
// Valid/ready bundle for the InvMixColumns sequencer.
// Input side, output side and busy status in one bundle.
interface inv_mixcolumns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out,
    output busy
  );
endinterface

// File: rtl/inv_mixcolumns_seq.sv
// AES InvMixColumns over a 128-bit state, LANES bytes per cycle.
// IDLE captures, RUN fills the result register, DONE holds it.
module inv_mixcolumns_seq #(
  parameter int LANES = 1
) (
  input  logic clk,
  input  logic rst_n,
  inv_mixcolumns_seq_if.slave bus
);

  localparam int N = 16 / LANES;
  localparam logic [3:0] LAST = 4'(N - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("inv_mixcolumns_seq: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [3:0]   idx;
  logic [127:0] src;
  logic [127:0] res;

  logic [3:0]   lane_k   [LANES];
  logic [7:0]   lane_val [LANES];

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(
    input logic [7:0] b
  );
    logic [7:0] b2;
    logic [7:0] b4;
    logic [7:0] b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return b8 ^ b;
  endfunction

  function automatic logic [7:0] mul0b(
    input logic [7:0] b
  );
    logic [7:0] b2;
    logic [7:0] b4;
    logic [7:0] b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return b8 ^ b2 ^ b;
  endfunction

  function automatic logic [7:0] mul0d(
    input logic [7:0] b
  );
    logic [7:0] b2;
    logic [7:0] b4;
    logic [7:0] b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return b8 ^ b4 ^ b;
  endfunction

  function automatic logic [7:0] mul0e(
    input logic [7:0] b
  );
    logic [7:0] b2;
    logic [7:0] b4;
    logic [7:0] b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return b8 ^ b4 ^ b2;
  endfunction

  // Rotating the column by 8r lines byte r up with the 0e tap.
  function automatic logic [7:0] inv_byte(
    input logic [31:0] col,
    input logic [1:0]  r
  );
    logic [63:0] dbl;
    logic [31:0] w;
    dbl = {col, col} >> {r, 3'b000};
    w   = dbl[31:0];
    return mul0e(w[7:0])   ^
           mul0b(w[15:8])  ^
           mul0d(w[23:16]) ^
           mul09(w[31:24]);
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0]  k;
    logic [31:0] col;

    assign k           = idx * 4'(LANES) + 4'(l);
    assign col         = src[{k[3:2], 5'b00000} +: 32];
    assign lane_k[l]   = k;
    assign lane_val[l] = inv_byte(col, k[1:0]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; DONE always returns through IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nx = RUN;
      RUN:  if (idx == LAST) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Source capture, pass index and per-lane result writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      src <= '0;
      res <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            src <= bus.data_in;
            idx <= '0;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            res[{lane_k[l], 3'b000} +: 8] <= lane_val[l];
          end
          idx <= (idx == LAST) ? 4'd0 : idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.data_out  = res;

endmodule
